// File: rtl/sha_target_check.sv
// sha_target_check: two-stage "H <= target" compare on SHA hash-stage output,
// with golden nonces queued in a small result FIFO for the consumer.
// Optional feature: define SHA_TARGET_CHECK_STATS_EN to build the hash_cnt counter.
// Without it, hash_cnt is tied to zero.

`ifndef H_SIZE
`define H_SIZE 256
`endif
`ifndef WORD_S
`define WORD_S 32
`endif

module sha_target_check #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [`H_SIZE-1:0]   H,
    input  logic [`WORD_S-1:0]   nonce,
    input  logic [`H_SIZE-1:0]   target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [`WORD_S-1:0]   out_nonce,
    output logic                 fifo_full,
    output logic [15:0]          drop_cnt,
    output logic [31:0]          hash_cnt
);

    localparam int unsigned HW   = `H_SIZE;
    localparam int unsigned HALF = HW / 2;
    localparam int unsigned WW   = `WORD_S;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;

    logic          rst_hold;
    logic          s1_valid;
    logic          s1_lt_hi;
    logic          s1_eq_hi;
    logic          s1_le_lo;
    logic [WW-1:0] s1_nonce;

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          hit_c;
    logic          empty_c;
    logic          pop_c;
    logic          wr_c;

    // Blocks en for the first edge after reset release so sampling starts on the second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_hold <= 1'b1;
        else       rst_hold <= 1'b0;
    end

    // Stage 1: split 256-bit compare into per-half flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_lt_hi <= 1'b0;
            s1_eq_hi <= 1'b0;
            s1_le_lo <= 1'b0;
            s1_nonce <= '0;
        end else begin
            s1_valid <= en & ~rst_hold;
            if (en) begin
                s1_lt_hi <= H[HW-1:HALF] <  target[HW-1:HALF];
                s1_eq_hi <= H[HW-1:HALF] == target[HW-1:HALF];
                s1_le_lo <= H[HALF-1:0]  <= target[HALF-1:0];
                s1_nonce <= nonce;
            end
        end
    end

    // Stage 2 hit decision and FIFO control.
    always_comb begin
        hit_c     = s1_valid & (s1_lt_hi | (s1_eq_hi & s1_le_lo));
        empty_c   = (wr_ptr == rd_ptr);
        fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        out_valid = ~empty_c;
        pop_c     = out_valid & out_ready;
        wr_c      = hit_c & (~fifo_full | pop_c);
        out_nonce = mem[rd_ptr[AW-1:0]];
    end

    // FIFO storage; cleared on reset so out_nonce reads zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else if (wr_c) begin
            mem[wr_ptr[AW-1:0]] <= s1_nonce;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_c)  wr_ptr <= wr_ptr + PW'(1);
            if (pop_c) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Saturating count of hits lost to a full FIFO with no same-edge pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (hit_c && fifo_full && !pop_c && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'(1);
        end
    end

`ifdef SHA_TARGET_CHECK_STATS_EN
    // Wrapping count of hashes that entered stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         hash_cnt <= '0;
        else if (s1_valid) hash_cnt <= hash_cnt + 32'(1);
    end
`else
    assign hash_cnt = '0;
`endif

endmodule

// File: doc/sha_target_check.md
SHA_TARGET_CHECK -- requirements
Module: sha_target_check

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, >= 2).
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  hash-valid strobe, driven by the SHA hash stage en_o.
REQ-005 SHALL have port H  input  `H_SIZE  final hash from the SHA hash stage.
REQ-006 SHALL have port nonce  input  `WORD_S  nonce that produced H.
REQ-007 SHALL have port target  input  `H_SIZE  difficulty target, sampled together with H.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port out_nonce  output  `WORD_S  golden nonce at FIFO head.
REQ-011 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port drop_cnt  output  16  count of hits lost to a full FIFO.
REQ-013 SHALL have port hash_cnt  output  32  count of hashes checked (see Configuration).

Function
REQ-014 SHALL treat H and target as unsigned `H_SIZE-bit integers, bit `H_SIZE-1 most significant, no byte or word reordering.
REQ-015 SHALL declare a hit when H <= target.
REQ-016 Stage 1 SHALL, at the edge where en=1, register valid, nonce, lt_hi/eq_hi (upper halves) and le_lo (lower halves).
REQ-017 Stage 2 SHALL, one edge later, compute hit = lt_hi | (eq_hi & le_lo) and push nonce into the FIFO if hit.
REQ-018 Latency SHALL be fixed: en sampled at edge k -> entry visible on out_valid/out_nonce after edge k+1 (FIFO previously empty).
REQ-019 SHALL accept en=1 every cycle with no stalls; en has no backpressure.
REQ-020 A pop SHALL occur at an edge where out_valid=1 and out_ready=1; out_ready with out_valid=0 is ignored.
REQ-021 FIFO SHALL be first-in first-out; out_nonce SHALL equal the head entry whenever out_valid=1 and is don't-care otherwise.
REQ-022 Push while full without simultaneous pop SHALL discard the nonce and increment drop_cnt, saturating at 16'hFFFF.
REQ-023 Push and pop at the same edge SHALL both take effect, including when full (no drop) and when holding one entry.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or occupancy counter.
REQ-025 Non-hit hashes SHALL cause no FIFO or drop_cnt change.

Reset
REQ-026 reset=1 SHALL immediately clear stage-1/stage-2 valid, FIFO pointers, drop_cnt and hash_cnt regardless of clk.
REQ-027 During and after reset, out_valid=0, fifo_full=0, drop_cnt=0, hash_cnt=0, out_nonce=0 until the first push.
REQ-028 Hashes in flight when reset asserts SHALL be discarded, never pushed.
REQ-029 Release SHALL be synchronized so the first en can be sampled at the second rising edge after deassertion.

Configuration
REQ-030 With macro SHA_TARGET_CHECK_STATS_EN defined, hash_cnt SHALL increment by 1 for each stage-1 valid hash, wrapping 32'hFFFFFFFF -> 0.
REQ-031 Without SHA_TARGET_CHECK_STATS_EN, hash_cnt SHALL be tied to 0 and its counter SHALL not be synthesized; all other behaviour is unchanged.

Verification
REQ-032 target=all-ones, en pulse with nonce=32'h00000001 -> out_valid=1 after edge k+1, out_nonce=32'h00000001.
REQ-033 target=256'h0, H=256'h1 -> no push, out_valid stays 0; H=256'h0 -> hit (equality boundary).
REQ-034 target upper half=0, lower half=all-ones; H upper=0/lower=5 -> hit; H upper=1/lower=0 -> no hit.
REQ-035 out_ready=0, 6 consecutive hits (nonces 10..15), FIFO_DEPTH=4 -> fifo_full=1, drop_cnt=2; then drain -> 10,11,12,13.
REQ-036 FIFO full, hit arrives at edge with out_ready=1 -> head popped, new nonce stored, drop_cnt unchanged.
REQ-037 reset asserted mid-burst between edges -> outputs zero immediately; with STATS_EN, 3 hashes after release -> hash_cnt=3.
